// File: rtl/mimosa_timing_pkg.sv
// Shared timing definitions for the creature-model timebase: channel FSM states
// and default sizing constants.
package mimosa_timing_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCount,
    StPend
  } ch_state_e;

  localparam int unsigned BaseDivDefault = 14;
  localparam int unsigned RateWDefault   = 2;
  localparam int unsigned NChDefault     = 2;
  localparam int unsigned CntWDefault    = 8;

  // Channel carrying the speech-start request.
  localparam int unsigned CH_SPEECH = 0;

endpackage

// File: rtl/tick_channel.sv
// One periodic event channel: counts model ticks, wraps at the programmed period and
// issues a pulse, deferring it while the consumer is busy.
module tick_channel
  import mimosa_timing_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             busy_i,
  output logic             pulse_o,
  output logic             overrun_o
);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             overrun_q, overrun_d;
  logic             wrap;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;
    overrun_d = overrun_q;
    // >= so that a period lowered below the running count wraps on the next tick.
    wrap      = tick_i && (cnt_q >= (period_i - CNT_W'(1)));

    if (period_i == '0) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StCount;
        end
        StCount: begin
          if (tick_i) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
          end
          if (wrap) begin
            if (busy_i) begin
              state_d = StPend;
            end else begin
              pulse_d = 1'b1;
            end
          end
        end
        StPend: begin
          if (tick_i) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
          end
          // A wrap coinciding with busy falling is folded into the pending pulse.
          if (!busy_i) begin
            pulse_d = 1'b1;
            state_d = StCount;
          end else if (wrap) begin
            overrun_d = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StCount;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      overrun_q <= overrun_d;
    end
  end

  assign pulse_o   = pulse_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/model_tick_scheduler.sv
// Model timebase: heartbeat-scaled tick prescaler with a pin-level square wave,
// driving N_CH independently programmable event channels.
module model_tick_scheduler
  import mimosa_timing_pkg::*;
#(
  parameter int unsigned BASE_DIV = BaseDivDefault,
  parameter int unsigned RATE_W   = RateWDefault,
  parameter int unsigned N_CH     = NChDefault,
  parameter int unsigned CNT_W    = CntWDefault
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [RATE_W-1:0]     heartbeat,
  input  logic                  freeze,
  input  logic [N_CH*CNT_W-1:0] period,
  input  logic [N_CH-1:0]       ch_busy,
  output logic                  model_tick,
  output logic                  model_clk_out,
  output logic [N_CH-1:0]       ch_pulse,
  output logic [N_CH-1:0]       ch_overrun
);

  logic [BASE_DIV-1:0] pre_cnt_q, pre_cnt_d;
  logic [BASE_DIV-1:0] pre_last;
  logic [RATE_W-1:0]   rate_q, rate_d, rate_eff;
  logic                init_q, init_d;
  logic                tick_q, tick_d;
  logic                clk_out_q, clk_out_d;

  always_comb begin
    // Until the first edge after reset the rate is taken live, then it is latched.
    rate_eff  = init_q ? heartbeat : rate_q;
    // L - 1 with L = 2^(BASE_DIV - rate) is an all-ones mask shifted right by rate.
    pre_last  = {BASE_DIV{1'b1}} >> rate_eff;
    pre_cnt_d = pre_cnt_q;
    rate_d    = init_q ? heartbeat : rate_q;
    init_d    = 1'b0;
    tick_d    = 1'b0;

    if (!freeze) begin
      if (pre_cnt_q == pre_last) begin
        pre_cnt_d = '0;
        tick_d    = 1'b1;
        rate_d    = heartbeat;
      end else begin
        pre_cnt_d = pre_cnt_q + BASE_DIV'(1);
      end
    end

    clk_out_d = clk_out_q ^ tick_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      rate_q    <= '0;
      init_q    <= 1'b1;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      rate_q    <= rate_d;
      init_q    <= init_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign model_tick    = tick_q;
  assign model_clk_out = clk_out_q;

  for (genvar i = 0; i < N_CH; i++) begin : gen_ch
    tick_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick_i   (tick_q),
      .period_i (period[i*CNT_W +: CNT_W]),
      .busy_i   (ch_busy[i]),
      .pulse_o  (ch_pulse[i]),
      .overrun_o(ch_overrun[i])
    );
  end

endmodule

// File: tb/tb_model_tick_scheduler.sv
// Self-checking bench for model_tick_scheduler: directed scenarios plus randomized
// stimulus against a cycle-level behavioural model.
module tb_model_tick_scheduler;

  localparam int unsigned BaseDiv = 4;
  localparam int unsigned RateW   = 2;
  localparam int unsigned NCh     = 2;
  localparam int unsigned CntW    = 4;

  logic             clk;
  logic             rst_n;
  logic [RateW-1:0] heartbeat;
  logic             freeze;
  logic [7:0]       period;
  logic [1:0]       ch_busy;
  logic             model_tick;
  logic             model_clk_out;
  logic [1:0]       ch_pulse;
  logic [1:0]       ch_overrun;

  int n_pass;
  int n_total;
  int cyc;

  // Behavioural model state.
  int       m_el;
  int       m_len;
  bit       m_first;
  bit       m_tick;
  bit       m_clk;
  bit [1:0] m_pulse;
  bit [1:0] m_ovr;
  bit [1:0] m_pend;
  bit [1:0] m_en;
  int       m_cnt[2];

  model_tick_scheduler #(
    .BASE_DIV(BaseDiv),
    .RATE_W  (RateW),
    .N_CH    (NCh),
    .CNT_W   (CntW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .heartbeat    (heartbeat),
    .freeze       (freeze),
    .period       (period),
    .ch_busy      (ch_busy),
    .model_tick   (model_tick),
    .model_clk_out(model_clk_out),
    .ch_pulse     (ch_pulse),
    .ch_overrun   (ch_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic reset_assert();
    rst_n = 1'b0;
    #1;
    m_el    = 0;
    m_len   = 0;
    m_first = 1'b1;
    m_tick  = 1'b0;
    m_clk   = 1'b0;
    m_pulse = '0;
    m_ovr   = '0;
    m_pend  = '0;
    m_en    = 2'b11;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  task automatic reset_release();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  task automatic do_reset();
    reset_assert();
    reset_release();
  endtask

  // Advance one clock: update the model from the inputs seen at this edge, then step.
  task automatic step();
    bit [1:0] np;
    bit       nt;
    bit       wrapped;
    int       p;
    np = '0;
    nt = 1'b0;
    if (m_first) begin
      m_len   = 1 << (BaseDiv - int'(heartbeat));
      m_first = 1'b0;
    end
    for (int ch = 0; ch < 2; ch++) begin
      p = int'(period[ch*4 +: 4]);
      if (p == 0) begin
        m_cnt[ch]  = 0;
        m_pend[ch] = 1'b0;
      end else if (m_en[ch]) begin
        wrapped = 1'b0;
        if (m_tick) begin
          if (m_cnt[ch] >= p - 1) begin
            m_cnt[ch] = 0;
            wrapped   = 1'b1;
          end else begin
            m_cnt[ch] = m_cnt[ch] + 1;
          end
        end
        if (m_pend[ch]) begin
          if (!ch_busy[ch]) begin
            np[ch]     = 1'b1;
            m_pend[ch] = 1'b0;
          end else if (wrapped) begin
            m_ovr[ch] = 1'b1;
          end
        end else if (wrapped) begin
          if (ch_busy[ch]) m_pend[ch] = 1'b1;
          else np[ch] = 1'b1;
        end
      end
      m_en[ch] = (p != 0);
    end
    if (!freeze) begin
      m_el = m_el + 1;
      if (m_el == m_len) begin
        nt    = 1'b1;
        m_el  = 0;
        m_len = 1 << (BaseDiv - int'(heartbeat));
      end
    end
    m_tick  = nt;
    if (nt) m_clk = ~m_clk;
    m_pulse = np;
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic test_reset();
    heartbeat = '0;
    freeze    = 1'b0;
    period    = '0;
    ch_busy   = '0;
    reset_assert();
    n_total++;
    if (model_tick !== 1'b0) $display("FAIL reset_tick got %b exp 0", model_tick);
    else n_pass++;
    n_total++;
    if (model_clk_out !== 1'b0) $display("FAIL reset_clk got %b exp 0", model_clk_out);
    else n_pass++;
    n_total++;
    if (ch_pulse !== 2'b00) $display("FAIL reset_pulse got %b exp 00", ch_pulse);
    else n_pass++;
    n_total++;
    if (ch_overrun !== 2'b00) $display("FAIL reset_overrun got %b exp 00", ch_overrun);
    else n_pass++;
    reset_release();
  endtask

  task automatic test_tick_rate();
    bit et, ec;
    heartbeat = 2'd0;
    period    = '0;
    ch_busy   = '0;
    freeze    = 1'b0;
    do_reset();
    for (int c = 1; c <= 50; c++) begin
      step();
      et = (c == 16) || (c == 32) || (c == 48);
      ec = ((c >= 16) && (c < 32)) || (c >= 48);
      n_total++;
      if (model_tick !== et) $display("FAIL tick_rate c=%0d got %b exp %b", c, model_tick, et);
      else n_pass++;
      n_total++;
      if (model_clk_out !== ec)
        $display("FAIL clk_out c=%0d got %b exp %b", c, model_clk_out, ec);
      else n_pass++;
    end
  endtask

  task automatic test_heartbeat_change();
    bit et;
    heartbeat = 2'd0;
    do_reset();
    for (int c = 1; c <= 30; c++) begin
      step();
      if (c == 5) heartbeat = 2'd2;
      et = (c == 16) || ((c > 16) && ((c - 16) % 4 == 0));
      n_total++;
      if (model_tick !== et) $display("FAIL hb_change c=%0d got %b exp %b", c, model_tick, et);
      else n_pass++;
    end
  endtask

  task automatic test_channel_pulse();
    bit ep;
    heartbeat = 2'd3;
    period    = 8'h03;
    ch_busy   = '0;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      step();
      ep = (c >= 7) && ((c - 7) % 6 == 0);
      n_total++;
      if (ch_pulse !== {1'b0, ep})
        $display("FAIL ch_pulse c=%0d got %b exp %b", c, ch_pulse, {1'b0, ep});
      else n_pass++;
    end
  endtask

  task automatic test_busy_defer();
    bit ep, eo;
    heartbeat = 2'd3;
    period    = 8'h02;
    ch_busy   = 2'b01;
    do_reset();
    for (int c = 1; c <= 12; c++) begin
      step();
      if (c == 10) ch_busy = 2'b00;
      ep = (c == 11);
      eo = (c >= 9);
      n_total++;
      if (ch_pulse[0] !== ep) $display("FAIL defer_pulse c=%0d got %b exp %b", c, ch_pulse[0], ep);
      else n_pass++;
      n_total++;
      if (ch_overrun[0] !== eo)
        $display("FAIL defer_overrun c=%0d got %b exp %b", c, ch_overrun[0], eo);
      else n_pass++;
    end
    for (int c = 13; c <= 24; c++) step();
    n_total++;
    if (ch_overrun !== 2'b01) $display("FAIL overrun_sticky got %b exp 01", ch_overrun);
    else n_pass++;
  endtask

  task automatic test_freeze();
    bit et, ep;
    heartbeat = 2'd0;
    period    = '0;
    ch_busy   = '0;
    freeze    = 1'b0;
    do_reset();
    for (int c = 1; c <= 30; c++) begin
      step();
      if (c == 5) freeze = 1'b1;
      if (c == 15) freeze = 1'b0;
      et = (c == 26);
      n_total++;
      if (model_tick !== et) $display("FAIL freeze_tick c=%0d got %b exp %b", c, model_tick, et);
      else n_pass++;
    end
    heartbeat = 2'd3;
    period    = 8'h05;
    do_reset();
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 7) period = 8'h02;
      ep = (c == 9);
      n_total++;
      if (ch_pulse[0] !== ep)
        $display("FAIL period_lower c=%0d got %b exp %b", c, ch_pulse[0], ep);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit ep;
    heartbeat = 2'd3;
    period    = 8'h02;
    ch_busy   = 2'b01;
    freeze    = 1'b0;
    do_reset();
    for (int c = 1; c <= 10; c++) step();
    n_total++;
    if ({model_tick, model_clk_out, ch_overrun[0]} !== 3'b111)
      $display("FAIL pre_reset_state got %b exp 111", {model_tick, model_clk_out, ch_overrun[0]});
    else n_pass++;
    reset_assert();
    n_total++;
    if ({model_tick, model_clk_out, ch_pulse, ch_overrun} !== 6'b0)
      $display("FAIL mid_reset_outputs got %b exp 000000",
               {model_tick, model_clk_out, ch_pulse, ch_overrun});
    else n_pass++;
    ch_busy = 2'b00;
    reset_release();
    for (int c = 1; c <= 6; c++) begin
      step();
      ep = (c == 5);
      n_total++;
      if (ch_pulse[0] !== ep)
        $display("FAIL post_reset_pulse c=%0d got %b exp %b", c, ch_pulse[0], ep);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      heartbeat   = RateW'($urandom_range(0, 3));
      period[3:0] = 4'($urandom_range(1, 15));
      period[7:4] = 4'($urandom_range(0, 15));
      ch_busy     = '0;
      freeze      = 1'b0;
      do_reset();
      for (int c = 0; c < 200; c++) begin
        if ($urandom_range(0, 5) == 0) ch_busy[0] = ~ch_busy[0];
        if ($urandom_range(0, 5) == 0) ch_busy[1] = ~ch_busy[1];
        if ($urandom_range(0, 40) == 0) heartbeat = RateW'($urandom_range(0, 3));
        if ($urandom_range(0, 80) == 0) period[3:0] = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 80) == 0) period[7:4] = 4'($urandom_range(0, 15));
        freeze = !m_tick && ($urandom_range(0, 9) == 0);
        step();
        n_total++;
        if (model_tick !== m_tick)
          $display("FAIL rnd_tick it=%0d c=%0d got %b exp %b", it, c, model_tick, m_tick);
        else n_pass++;
        n_total++;
        if (model_clk_out !== m_clk)
          $display("FAIL rnd_clk it=%0d c=%0d got %b exp %b", it, c, model_clk_out, m_clk);
        else n_pass++;
        n_total++;
        if (ch_pulse !== m_pulse)
          $display("FAIL rnd_pulse it=%0d c=%0d got %b exp %b", it, c, ch_pulse, m_pulse);
        else n_pass++;
        n_total++;
        if (ch_overrun !== m_ovr)
          $display("FAIL rnd_overrun it=%0d c=%0d got %b exp %b", it, c, ch_overrun, m_ovr);
        else n_pass++;
      end
    end
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    heartbeat = '0;
    freeze    = 1'b0;
    period    = '0;
    ch_busy   = '0;
    test_reset();
    test_tick_rate();
    test_heartbeat_change();
    test_channel_pulse();
    test_busy_defer();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
